// File: rtl/gray_rd_arbiter.sv
// Two-master arbiter for the shared gray-image read port: round-robin between
// window engines, with a master locked in for a whole burst (capped at MAX_BURST).
module gray_rd_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [DATA_W-1:0] gray_data,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_last,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_last,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata
);

    localparam int               CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state;
    logic             rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic             rsel;
    logic             sel;
    logic             sel_last;
    logic             burst_end;

    always_comb begin
        sel = 1'b0;
        case (state)
            OWN0:    sel = 1'b0;
            OWN1:    sel = 1'b1;
            default: sel = (m0_req && m1_req) ? rr_ptr : m1_req;
        endcase
    end

    // Grants are qualified by reset so the port goes quiet as soon as reset asserts.
    assign m0_gnt = reset & gray_ready & m0_req & ~sel & (state == IDLE || state == OWN0);
    assign m1_gnt = reset & gray_ready & m1_req &  sel & (state == IDLE || state == OWN1);
    assign gray_req = m0_gnt | m1_gnt;

    assign gray_addr = (state == IDLE && !gray_req) ? '0 : (sel ? m1_addr : m0_addr);

    assign sel_last  = sel ? m1_last : m0_last;
    assign burst_end = sel_last || (beat_cnt == LAST_CNT);

    // Data returns one cycle after the strobe; rsel remembers who issued it.
    assign m0_rdata = rsel ? '0 : gray_data;
    assign m1_rdata = rsel ? gray_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            beat_cnt  <= '0;
            rsel      <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt;
            m1_rvalid <= m1_gnt;
            if (gray_req) begin
                rsel <= sel;
                if (burst_end) begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                    rr_ptr   <= ~sel;
                end else begin
                    state    <= sel ? OWN1 : OWN0;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/gray_rd_arbiter.md
Name: gray_rd_arbiter

Overview:
- Shares the single gray-image read port (gray_req/gray_ready/gray_addr/gray_data, 128x128 8-bit, 14-bit address) between two window engines, m0 and m1 (e.g. the LBP engine and a second 3x3 filter engine).
- Round-robin arbitration with burst locking: a master keeps the port for a whole window fetch, so the two engines' reads never interleave inside one burst.
- Returned data is routed to the master that issued the read.

Parameters:
- ADDR_W, 14, gray/master address width.
- DATA_W, 8, pixel width.
- MAX_BURST, 9, maximum beats per ownership; 1 gives pure per-beat round-robin.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- gray_ready  in  1  memory able to accept reads (level).
- gray_req  out  1  read strobe to memory.
- gray_addr  out  ADDR_W  read address to memory.
- gray_data  in  DATA_W  read data, valid the cycle after the accepted strobe.
- m0_req  in  1  master 0 read request, held until granted.
- m0_addr  in  ADDR_W  master 0 read address.
- m0_last  in  1  current m0 beat is the last of its burst.
- m0_gnt  out  1  m0 beat accepted this cycle.
- m0_rvalid  out  1  m0_rdata valid.
- m0_rdata  out  DATA_W  read data to m0.
- m1_req, m1_addr, m1_last, m1_gnt, m1_rvalid, m1_rdata: same as m0, for master 1.

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, rr_ptr (master favoured next in IDLE), beat_cnt of width clog2(MAX_BURST+1), rsel, m0_rvalid, m1_rvalid.
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, rsel=0, m0_rvalid=m1_rvalid=0. Combinational outputs evaluate to gray_req=0, m0_gnt=m1_gnt=0, gray_addr=0 while idle with no requests.
- Selection (combinational):
  - OWNx: sel=x.
  - IDLE, only one master requesting: sel=that master.
  - IDLE, both requesting: sel=rr_ptr.
- mX_gnt = gray_ready & mX_req & (sel==X) & (state==IDLE or state==OWNX).
- gray_req = m0_gnt | m1_gnt.
- gray_addr = m1_addr when sel=1, else m0_addr. It is 0 when no grant and state is IDLE.
- Beat accepted = gnt high at a rising edge. The master may change addr/last after each accepted beat.
- Read return: mX_rvalid is a register set to mX_gnt of the previous cycle. mX_rdata = gray_data when rsel==X, else 0. rsel is registered from sel on each accepted beat. Latency is addr to rdata = 1 cycle.
- Burst end: the accepted beat has mX_last=1, or beat_cnt+1==MAX_BURST. On burst end:
  - state -> IDLE, beat_cnt -> 0, rr_ptr -> other master.
  - A single-beat burst accepted in IDLE with last=1 stays in IDLE and flips rr_ptr.
- Accepted beat that is not a burst end: state -> OWNx, beat_cnt increments.
- Handoff: the other master can be granted in the cycle directly after burst end (IDLE grants combinationally), so there is no bubble.
- Owner drops req mid-burst: ownership is held and the other master is not granted. beat_cnt does not advance until the owner's next accepted beat.
- gray_ready=0: no grants, state/beat_cnt/rr_ptr hold. Rvalid for a beat already accepted still asserts next cycle.
- A master's req/addr/last must be stable while req=1 and gnt=0. No checking is done on this.
- Reset asserted mid-burst: all registers clear immediately (asynchronous). An in-flight rvalid is dropped.

Test Plan:
- Solo burst: m0 only, 9 beats, addr 0,1,2,128,129,130,256,257,258, last on beat 9, gray_ready=1 -> m0_gnt high for 9 consecutive cycles; m0_rvalid lags by 1 with matching memory data; state back to IDLE; rr_ptr=1.
- Contention: both request at the same time after reset -> m0 owns for 9 beats, m1_gnt=0 throughout; m1 granted on cycle 10 with no bubble; after m1's 9 beats, m0 is granted again.
- MAX_BURST cap: m1 never asserts last over 12 beats, MAX_BURST=9 -> m1 released after beat 9; pending m0 granted on the next cycle; m1's beats 10-12 wait for m0's burst to end.
- Stall: gray_ready low for 3 cycles mid-burst after beat 4 -> no gnt for 3 cycles; beat 4 rvalid still asserts; beats 5-9 resume; total 9 beats.
- Owner gap: m0 drops req for 2 cycles after beat 3 while m1 requests -> m1_gnt stays 0; m0 resumes and finishes beats 4-9; m1 then granted.
- Async reset: assert reset=0 mid-burst between clock edges -> gray_req, gnts and rvalids go 0 immediately; after release, m0 wins the first contention (rr_ptr=0).
